muldiv_ctrl: RTL

//  Sequences the EX-stage multiply/divide resource for MULT/MULTU/DIV/DIVU. Accepts one op from EX,

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_mul_pipe.sv | 55 +++++
 rtl/muldiv_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide controller.
package muldiv_pkg;

  localparam int MD_W = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_BUSY = 2'b01,
    ST_DIV_BUSY = 2'b10,
    ST_DONE     = 2'b11
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_mul_pipe.sv
// MUL_LAT-stage multiplier: signed products are formed from operand magnitudes
// and negated when the operand signs differ; a valid bit travels alongside.
module muldiv_mul_pipe
  import muldiv_pkg::*;
#(
  parameter int W       = MD_W,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid_i,
  input  logic           signed_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           out_valid_o,
  output logic [2*W-1:0] prod_o
);

  logic           neg_a_s, neg_b_s;
  logic [W-1:0]   mag_a_s, mag_b_s;
  logic [2*W-1:0] umul_s, prod_d;
  logic [2*W-1:0] prod_q [MUL_LAT];
  logic [MUL_LAT-1:0] vld_q;

  // Magnitude multiply followed by conditional two's-complement negation.
  always_comb begin
    neg_a_s = signed_i & a_i[W-1];
    neg_b_s = signed_i & b_i[W-1];
    mag_a_s = neg_a_s ? (~a_i + W'(1)) : a_i;
    mag_b_s = neg_b_s ? (~b_i + W'(1)) : b_i;
    umul_s  = {W'(0), mag_a_s} * {W'(0), mag_b_s};
    prod_d  = (neg_a_s ^ neg_b_s) ? (~umul_s + (2*W)'(1)) : umul_s;
  end

  // Product and valid shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        prod_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      prod_q[0] <= prod_d;
      vld_q[0]  <= in_valid_i;
      for (int i = 1; i < MUL_LAT; i++) begin
        prod_q[i] <= prod_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign prod_o      = prod_q[MUL_LAT-1];
  assign out_valid_o = vld_q[MUL_LAT-1];

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer: pipeline stall, divider handshake, {HI,LO} hold.
// Optional MULDIV_DIV0_FAST_EN: divide by zero completes without the divider.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int W       = MD_W,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic           req_valid_i,
  input  logic [1:0]     op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           pipe_stall_i,
  output logic           stall_o,
  output logic           result_valid_o,
  output logic [2*W-1:0] result_o,
  output logic           div_start_o,
  output logic           div_signed_o,
  output logic           div_annul_o,
  output logic [W-1:0]   div_a_o,
  output logic [W-1:0]   div_b_o,
  input  logic           div_ready_i,
  input  logic [2*W-1:0] div_result_i
);

  localparam int CW = $clog2(MUL_LAT + 1);

  md_state_e      state_q, state_d;
  md_op_e         op_q, op_d, op_in_s;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*W-1:0] res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accept_s, mul_start_s, mul_valid_s;
  logic [2*W-1:0] mul_prod_s;

  assign op_in_s     = md_op_e'(op_i);
  assign accept_s    = req_valid_i & ~flush_i;
  // The multiplier takes the live operands on the accept cycle so its output lines up with the counter.
  assign mul_start_s = (state_q == ST_IDLE) & accept_s & ~md_is_div(op_in_s);

  muldiv_mul_pipe #(.W(W), .MUL_LAT(MUL_LAT)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (mul_start_s),
    .signed_i   (md_is_signed(op_in_s)),
    .a_i        (a_i),
    .b_i        (b_i),
    .out_valid_o(mul_valid_s),
    .prod_o     (mul_prod_s)
  );

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d = op_in_s;
          a_d  = a_i;
          b_d  = b_i;
          if (!md_is_div(op_in_s)) begin
            state_d = ST_MUL_BUSY;
            cnt_d   = CW'(MUL_LAT - 1);
          end
`ifdef MULDIV_DIV0_FAST_EN
          else if (b_i == '0) begin
            state_d = ST_DONE;
            res_d   = {a_i, {W{1'b1}}};
          end
`endif
          else begin
            state_d = ST_DIV_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (mul_valid_s) begin
          state_d = ST_DONE;
          res_d   = mul_prod_s;
        end else begin
          state_d = ST_MUL_BUSY;
        end
      end
      ST_DIV_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (div_ready_i) begin
          state_d = ST_DONE;
          res_d   = div_result_i;
        end else begin
          state_d = ST_DIV_BUSY;
        end
      end
      ST_DONE: begin
        if (flush_i || !pipe_stall_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall and divider handshake; flush suppresses start and raises annul in DIV_BUSY.
  always_comb begin
    stall_o      = 1'b0;
    div_start_o  = 1'b0;
    div_signed_o = 1'b0;
    div_annul_o  = 1'b0;
    case (state_q)
      ST_IDLE:     stall_o = accept_s;
      ST_MUL_BUSY: stall_o = ~flush_i;
      ST_DIV_BUSY: begin
        stall_o      = ~flush_i;
        div_start_o  = ~flush_i;
        div_signed_o = ~flush_i & (op_q == MD_DIV);
        div_annul_o  = flush_i;
      end
      ST_DONE:     stall_o = 1'b0;
      default:     stall_o = 1'b0;
    endcase
  end

  assign result_valid_o = (state_q == ST_DONE);
  assign result_o       = res_q;
  assign div_a_o        = a_q;
  assign div_b_o        = b_q;

endmodule
